// File: rtl/jcnt_monitor.sv
// jcnt_monitor: samples a Johnson code every cycle, decodes it to a phase index
// and one-hot vector, checks each step, tracks lock, and counts revolutions and faults.
module jcnt_monitor #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int REV_W    = 8,
    parameter int ERR_W    = 4,
    localparam int PW      = $clog2(2*WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     q,
    input  logic                 clr,
    output logic [PW-1:0]        phase,
    output logic [2*WIDTH-1:0]   onehot,
    output logic                 code_ok,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_W-1:0]     err_cnt,
    output logic [REV_W-1:0]     rev_cnt,
    output logic                 rev_pulse
);

    localparam int              CW       = $clog2(LOCK_CNT + 1);
    localparam logic [PW-1:0]   LAST_PH  = PW'(2*WIDTH - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACQ, LOCK, FAULT} state_t;

    state_t              state;
    logic [CW-1:0]       good_cnt;

    logic                dec_ok_p0;
    logic [PW-1:0]       dec_idx_p0;
    logic [2*WIDTH-1:0]  oh_p0;
    logic [PW-1:0]       next_ph;
    logic                step_good;
    logic                step_hold;
    logic                step_bad;
    logic                fault_ev;
    logic                rev_ev;

    // Legal code for phase k: k low ones for k<=WIDTH, then ones shifted left.
    function automatic logic [WIDTH-1:0] jcode(input int k);
        if (k <= WIDTH)
            jcode = ~({WIDTH{1'b1}} << k);
        else
            jcode = {WIDTH{1'b1}} << (k - WIDTH);
    endfunction

    // Decode the sampled code against every legal Johnson state.
    always_comb begin
        dec_ok_p0  = 1'b0;
        dec_idx_p0 = '0;
        oh_p0      = '0;
        for (int k = 0; k < 2*WIDTH; k++) begin
            if (q == jcode(k)) begin
                dec_ok_p0  = 1'b1;
                dec_idx_p0 = PW'(k);
            end
        end
        if (dec_ok_p0)
            oh_p0[dec_idx_p0] = 1'b1;
    end

    // Classify the step relative to the last registered phase.
    always_comb begin
        next_ph   = (phase == LAST_PH) ? '0 : phase + 1'b1;
        step_good = dec_ok_p0 && (dec_idx_p0 == next_ph);
        step_hold = dec_ok_p0 && (dec_idx_p0 == phase);
        step_bad  = dec_ok_p0 && !step_good && !step_hold;
        fault_ev  = (state == LOCK) && (step_bad || !dec_ok_p0);
        rev_ev    = (state == LOCK) && step_good && (phase == LAST_PH);
    end

    assign locked = (state == LOCK);

    // Register decoded outputs, status counters and the lock FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase     <= '0;
            onehot    <= '0;
            code_ok   <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            rev_cnt   <= '0;
            rev_pulse <= 1'b0;
            state     <= IDLE;
            good_cnt  <= '0;
        end else begin
            code_ok   <= dec_ok_p0;
            onehot    <= oh_p0;
            if (dec_ok_p0)
                phase <= dec_idx_p0;

            // A fault or revolution in a clear cycle restarts its count at one.
            if (fault_ev) begin
                err     <= 1'b1;
                err_cnt <= clr ? ERR_W'(1) :
                           (err_cnt == ERR_MAX) ? ERR_MAX : err_cnt + 1'b1;
            end else if (clr) begin
                err     <= 1'b0;
                err_cnt <= '0;
            end

            if (rev_ev)
                rev_cnt <= clr ? REV_W'(1) : rev_cnt + 1'b1;
            else if (clr)
                rev_cnt <= '0;
            rev_pulse <= rev_ev;

            case (state)
                IDLE: begin
                    if (dec_ok_p0) begin
                        state    <= ACQ;
                        good_cnt <= '0;
                    end
                end
                ACQ: begin
                    if (!dec_ok_p0) begin
                        state <= IDLE;
                    end else if (step_good) begin
                        good_cnt <= good_cnt + 1'b1;
                        if (good_cnt == CW'(LOCK_CNT - 1))
                            state <= LOCK;
                    end else if (step_bad) begin
                        good_cnt <= '0;
                    end
                end
                LOCK: begin
                    if (fault_ev)
                        state <= FAULT;
                end
                FAULT: begin
                    if (dec_ok_p0) begin
                        state    <= ACQ;
                        good_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
